// File: rtl/pattern_det_pkg.sv
// -----------------------------------------------------------------------------
// pattern_det_pkg
// Shared constants for the serial pattern detector: output-mode selectors,
// the legal pattern-length range, and a helper that sizes the fill counter.
// -----------------------------------------------------------------------------
package pattern_det_pkg;

  // Output timing selectors for pattern_detector_param
  localparam int MODE_MEALY = 0;  // pulse in the same cycle as the final bit
  localparam int MODE_MOORE = 1;  // pulse one cycle after the final bit

  // Legal range for the pattern length
  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  // Bits needed to hold a fill count of 0..pat_len-1 (never narrower than 1).
  function automatic int fill_width(input int pat_len);
    int w;
    if (pat_len <= 2) begin
      w = 1;
    end else begin
      w = $clog2(pat_len);
    end
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (highest priority)
//   clr   in   synchronous clear to zero
//   inc   in   add one when not saturated
//   count out  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_r;

  // Count register: reset, then clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pattern_detector_param.sv
// -----------------------------------------------------------------------------
// pattern_detector_param
// Serial bit-pattern detector with selectable overlap and Mealy/Moore output.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   data_i        in   serial data bit
//   valid_i       in   qualifies data_i
//   clear_i       in   synchronous clear of history and match counter
//   pattern_o     out  one-cycle match pulse
//   match_count_o out  saturating number of matches seen
// -----------------------------------------------------------------------------
module pattern_detector_param
  import pattern_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 OVERLAP = 1,
  parameter int                 MODE    = MODE_MEALY,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             pattern_o,
  output logic [CNT_W-1:0] match_count_o
);

  localparam int                FILL_W   = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  // Refuse to elaborate with a pattern length outside the supported range.
  if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_pat_len
    $error("pattern_detector_param: PAT_LEN must be within 2..16");
  end

  logic [PAT_LEN-2:0] hist_r;
  logic [PAT_LEN-2:0] hist_nxt_s;
  logic [FILL_W-1:0]  fill_r;
  logic [FILL_W-1:0]  fill_nxt_s;
  logic [PAT_LEN-1:0] window_s;
  logic               accept_s;
  logic               match_s;
  logic               moore_r;

  // The candidate window is the stored history with the incoming bit appended.
  assign window_s = {hist_r, data_i};
  assign accept_s = valid_i & ~clear_i;
  assign match_s  = accept_s & (fill_r == FILL_MAX) & (window_s == PATTERN);

  // Next history / fill: clear wins, gaps hold, accepted bits shift in.
  always_comb begin
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    if (clear_i) begin
      fill_nxt_s = {FILL_W{1'b0}};
    end else if (valid_i) begin
      hist_nxt_s = window_s[PAT_LEN-2:0];
      // Non-overlapping mode consumes the matching bits entirely.
      if (match_s && (OVERLAP == 0)) begin
        fill_nxt_s = {FILL_W{1'b0}};
      end else if (fill_r != FILL_MAX) begin
        fill_nxt_s = fill_r + FILL_W'(1);
      end else begin
        fill_nxt_s = fill_r;
      end
    end else begin
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
    end
  end

  // History and fill registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= {(PAT_LEN-1){1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else begin
      hist_r <= hist_nxt_s;
      fill_r <= fill_nxt_s;
    end
  end

  // Delayed match pulse used when the output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      moore_r <= 1'b0;
    end else if (clear_i) begin
      moore_r <= 1'b0;
    end else begin
      moore_r <= match_s;
    end
  end

  // The combinational output is gated so reset can never leak a pulse.
  assign pattern_o = (MODE == MODE_MOORE) ? moore_r : (match_s & ~rst);

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_i),
    .inc   (match_s),
    .count (match_count_o)
  );

endmodule

// File: tb/tb_pattern_detector_param.sv
// -----------------------------------------------------------------------------
// tb_pattern_detector_param
// Directed bench: four detector variants share one input stream
// (defaults, non-overlapping, registered output, 2-bit counter).
// -----------------------------------------------------------------------------
module tb_pattern_detector_param;
  import pattern_det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0;
  logic valid = 1'b0;
  logic clear = 1'b0;

  logic       p_def, p_ov0, p_moore, p_c2;
  logic [7:0] c_def, c_ov0, c_moore;
  logic [1:0] c_c2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pattern_detector_param u_def (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
    .pattern_o(p_def), .match_count_o(c_def));

  pattern_detector_param #(.OVERLAP(0)) u_ov0 (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
    .pattern_o(p_ov0), .match_count_o(c_ov0));

  pattern_detector_param #(.MODE(MODE_MOORE)) u_moore (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
    .pattern_o(p_moore), .match_count_o(c_moore));

  pattern_detector_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid), .clear_i(clear),
    .pattern_o(p_c2), .match_count_o(c_c2));

  // Apply inputs on the falling edge, then settle briefly before sampling.
  task automatic drive(input logic d, input logic v, input logic c, input logic r);
    @(negedge clk);
    data = d; valid = v; clear = c; rst = r;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({p_def, p_ov0, p_moore, p_c2} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_pulse: got %b expected 0000", {p_def, p_ov0, p_moore, p_c2});
    end
    tests_run++;
    if ({c_def, c_ov0, c_moore} !== 24'd0 || c_c2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d %0d %0d %0d expected 0", c_def, c_ov0, c_moore, c_c2);
    end
  endtask

  task automatic test_overlap();
    logic s  [7];
    logic ea [7];
    logic eo [7];
    logic prev;
    s  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ea = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    prev = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(s[i], 1'b1, 1'b0, 1'b0);
      tests_run++;
      if (p_def !== ea[i]) begin
        tests_failed++;
        $display("FAIL overlap_pulse bit %0d: got %b expected %b", i + 1, p_def, ea[i]);
      end
      tests_run++;
      if (p_ov0 !== eo[i]) begin
        tests_failed++;
        $display("FAIL nonoverlap_pulse bit %0d: got %b expected %b", i + 1, p_ov0, eo[i]);
      end
      tests_run++;
      if (p_moore !== prev) begin
        tests_failed++;
        $display("FAIL moore_delayed bit %0d: got %b expected %b", i + 1, p_moore, prev);
      end
      prev = ea[i];
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (p_moore !== 1'b1) begin
      tests_failed++;
      $display("FAIL moore_last_pulse: got %b expected 1", p_moore);
    end
    tests_run++;
    if (c_def !== 8'd2 || c_ov0 !== 8'd1 || c_moore !== 8'd2 || c_c2 !== 2'd2) begin
      tests_failed++;
      $display("FAIL overlap_counts: got %0d %0d %0d %0d expected 2 1 2 2", c_def, c_ov0, c_moore, c_c2);
    end
  endtask

  task automatic test_gap();
    logic d [5];
    logic v [5];
    logic e [5];
    d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(d[i], v[i], 1'b0, 1'b0);
      tests_run++;
      if (p_def !== e[i]) begin
        tests_failed++;
        $display("FAIL gap_pulse step %0d: got %b expected %b", i, p_def, e[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (c_def !== 8'd1) begin
      tests_failed++;
      $display("FAIL gap_count: got %0d expected 1", c_def);
    end
  endtask

  task automatic test_moore();
    logic s [4];
    s = '{1'b1, 1'b1, 1'b0, 1'b1};
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(s[i], 1'b1, 1'b0, 1'b0);
      tests_run++;
      if (p_moore !== 1'b0) begin
        tests_failed++;
        $display("FAIL moore_early bit %0d: got %b expected 0", i + 1, p_moore);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (p_moore !== 1'b1) begin
      tests_failed++;
      $display("FAIL moore_pulse: got %b expected 1", p_moore);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (p_moore !== 1'b0 || c_moore !== 8'd1) begin
      tests_failed++;
      $display("FAIL moore_width: got %b/%0d expected 0/1", p_moore, c_moore);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] s;
    logic [15:0] e;
    int k;
    int k_sat;
    s = 16'b1101101101101101;
    e = 16'b0001001001001001;
    k = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(s[15-i], 1'b1, 1'b0, 1'b0);
      k_sat = (k > 3) ? 3 : k;
      tests_run++;
      if (c_c2 !== 2'(k_sat) || c_def !== 8'(k)) begin
        tests_failed++;
        $display("FAIL sat_count bit %0d: got %0d/%0d expected %0d/%0d", i + 1, c_c2, c_def, k_sat, k);
      end
      tests_run++;
      if (p_c2 !== e[15-i]) begin
        tests_failed++;
        $display("FAIL sat_pulse bit %0d: got %b expected %b", i + 1, p_c2, e[15-i]);
      end
      if (e[15-i]) k++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (c_c2 !== 2'd3 || c_def !== 8'd5) begin
      tests_failed++;
      $display("FAIL sat_final: got %0d/%0d expected 3/5", c_c2, c_def);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (c_c2 !== 2'd0 || c_def !== 8'd0) begin
      tests_failed++;
      $display("FAIL sat_clear: got %0d/%0d expected 0/0", c_c2, c_def);
    end
  endtask

  task automatic test_clear_rst();
    logic s [3];
    s = '{1'b1, 1'b1, 1'b0};
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(s[i], 1'b1, 1'b0, 1'b0);
    // Completing bit arrives while reset is held: must not pulse.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({p_def, p_ov0, p_c2} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_force_low: got %b expected 000", {p_def, p_ov0, p_c2});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (p_def !== 1'b0 || c_def !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_discard: got %b/%0d expected 0/0", p_def, c_def);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(s[i], 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (p_def !== 1'b0 || p_ov0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_priority_pulse: got %b%b expected 00", p_def, p_ov0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (c_def !== 8'd0 || p_moore !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_priority_count: got %0d/%b expected 0/0", c_def, p_moore);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_gap();
    test_moore();
    test_saturate();
    test_clear_rst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
